fifo_port_scheduler: RTL
========================

Name: fifo_port_scheduler

Overview:
- Shares the single write port of the 8-bit FIFO between NUM_REQ producers using round-robin arbitration.
- Sequences the FIFO read port into a valid/ready stream for one consumer.
- Sits directly between the producer blocks, the FIFO instance (wr_en, rd_en, buf_in, buf_out, buf_empty, buf_full, fifo_counter) and the downstream consumer.
- Guarantees the FIFO never sees a write while full or a read while empty.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_W, 8, data width; matches FIFO buf_in/buf_out.
- CNT_W, 8, width of fifo_counter.
- FIFO_DEPTH, 64, FIFO capacity in words.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  producer i holds req[i] high while it has a word.
- req_data  in  NUM_REQ*DATA_W  producer i word in slice [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  combinational one-hot; gnt[i]=1 means req_data slice i is accepted at this edge.
- arb_en  in  1  0 = freeze write acceptance; the read side keeps running.
- wr_en  out  1  registered FIFO write strobe.
- buf_in  out  DATA_W  registered FIFO write data.
- rd_en  out  1  combinational FIFO read strobe.
- buf_out  in  DATA_W  FIFO read data, valid the cycle after rd_en.
- buf_empty  in  1  FIFO empty flag.
- buf_full  in  1  FIFO full flag.
- fifo_counter  in  CNT_W  FIFO occupancy.
- out_valid  out  1  consumer data valid.
- out_data  out  DATA_W  consumer data.
- out_ready  in  1  consumer accepts out_data when out_valid&&out_ready at an edge.

Behaviour:
- Reset (asynchronous, rst=1): wr_en=0, buf_in=0, rd_pending=0, out_valid=0, out_data=0, rr pointer last=NUM_REQ-1 (requester 0 has highest priority). gnt=0 and rd_en=0 while rst is high.
- Write space: space = !buf_full && (fifo_counter + wr_en) < FIFO_DEPTH, computed at CNT_W+1 bits.
  - This counts the write still in flight.
  - Reads in progress are ignored, so the check is conservative.
- Write arbitration: when arb_en && space, grant the first i with req[i]=1, searching last+1, last+2, … modulo NUM_REQ. Otherwise gnt=0.
- Write register: on an edge with a grant, wr_en<=1, buf_in<=slice i, last<=i. Otherwise wr_en<=0 and buf_in holds.
- Write latency: producer word to FIFO write takes exactly 1 cycle. Peak rate is one word per cycle.
- The rr pointer changes only on an accepted grant. A requester that drops req before it is granted loses nothing.
- Read FSM, driven by flag rd_pending:
  - IDLE: rd_en = !buf_empty && (!out_valid || out_ready). If rd_en, go to FETCH (rd_pending<=1).
  - FETCH: rd_en=0. At the next edge, out_data<=buf_out, out_valid<=1, rd_pending<=0, back to IDLE.
  - out_valid clears on an edge where out_valid&&out_ready and no FETCH capture happens on that edge.
  - Sustained read rate is one word per 2 cycles. Read latency from rd_en to out_valid is 2 edges.
- Simultaneous events:
  - Write and read in the same cycle are independent; no interaction beyond what the FIFO itself does.
  - A FETCH capture while the consumer takes the old word is legal: the new word replaces it and out_valid stays 1.
- Stall rules:
  - out_valid && !out_ready → out_data and out_valid hold, and no rd_en.
  - arb_en falling mid-stream: a word already registered is still written; no further grants.
- Reset mid-operation: all in-flight write and read state is discarded. The FIFO is reset by the same rst.

Test Plan:
- Reset, all 4 req high, data 100/64/36/12, out_ready=0, arb_en=1 → gnt sequence 0,1,2,3,0…; wr_en high from edge 1; buf_in 100,64,36,12,…; exactly 64 writes, then gnt=0 with wr_en=0 and no write while buf_full.
- Only req[2] high for 3 cycles, then req[0] and req[2] both high → gnt[2] ×3, then gnt[0] and gnt[2] alternate starting with gnt[0].
- FIFO holding 3 words, out_ready=1 → rd_en pulses every 2nd cycle; out_valid follows each rd_en by 2 edges; outputs in FIFO order; rd_en stays 0 once buf_empty=1.
- out_ready=0 with out_valid=1 for 5 cycles → out_data stable; rd_en=0 throughout; a word follows 2 edges after out_ready rises.
- arb_en dropped with req held high → grants stop within the same cycle; the pending write completes; fifo_counter stops rising.
- rst pulsed for 20 ns mid-stream → wr_en=0 and out_valid=0 immediately; after release, requester 0 is granted first.

Source files
------------

// File: rtl/fifo_port_scheduler.sv
// fifo_port_scheduler
//
// Purpose: shares the single write port of a FIFO between NUM_REQ producers
// with round-robin arbitration, and turns the FIFO read port into a
// valid/ready stream for one consumer. The FIFO is never written while full
// and never read while empty.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   req, req_data     producer requests and words (slice i = producer i)
//   gnt               combinational one-hot grant (word accepted at this edge)
//   arb_en            0 freezes write acceptance; read side keeps running
//   wr_en, buf_in     registered FIFO write strobe and data
//   rd_en             combinational FIFO read strobe
//   buf_out           FIFO read data, valid the cycle after rd_en
//   buf_empty, buf_full, fifo_counter   FIFO status
//   out_valid, out_data, out_ready      consumer stream
module fifo_port_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      arb_en,
    output logic                      wr_en,
    output logic [DATA_W-1:0]         buf_in,
    output logic                      rd_en,
    input  logic [DATA_W-1:0]         buf_out,
    input  logic                      buf_empty,
    input  logic                      buf_full,
    input  logic [CNT_W-1:0]          fifo_counter,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready
);

    localparam int             IDX_W     = $clog2(NUM_REQ);
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [IDX_W:0] NREQ_EXT  = (IDX_W+1)'(NUM_REQ);

    typedef enum logic {
        RD_IDLE,
        RD_FETCH
    } rd_state_t;

    // Write side state
    logic               wr_en_q, wr_en_d;
    logic [DATA_W-1:0]  buf_in_q, buf_in_d;
    logic [IDX_W-1:0]   last_q, last_d;

    // Read side state
    rd_state_t          state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               rd_en_c;

    // Arbitration signals
    logic [CNT_W:0]     occ_ext;
    logic               space;
    logic               grant_any;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W:0]     rr_sum;
    logic [NUM_REQ-1:0] gnt_c;
    logic [DATA_W-1:0]  sel_data;

    // The write already registered but not yet seen by the FIFO counter is
    // counted as occupied; reads in flight are ignored (conservative).
    assign occ_ext = {1'b0, fifo_counter} + {{CNT_W{1'b0}}, wr_en_q};
    assign space   = !buf_full && (occ_ext < DEPTH_EXT);

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        rr_sum    = '0;
        if (!rst && arb_en && space) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                rr_sum = {1'b0, last_q} + (IDX_W+1)'(k);
                if (rr_sum >= NREQ_EXT) begin
                    rr_sum = rr_sum - NREQ_EXT;
                end
                if (!grant_any && req[rr_sum[IDX_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = rr_sum[IDX_W-1:0];
                end
            end
        end
    end

    always_comb begin
        gnt_c    = '0;
        sel_data = '0;
        if (grant_any) begin
            gnt_c[grant_idx] = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        wr_en_d  = grant_any;
        buf_in_d = grant_any ? sel_data : buf_in_q;
        last_d   = grant_any ? grant_idx : last_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q  <= 1'b0;
            buf_in_q <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
        end else begin
            wr_en_q  <= wr_en_d;
            buf_in_q <= buf_in_d;
            last_q   <= last_d;
        end
    end

    // Read FSM: IDLE issues rd_en when a word is available and the output
    // slot is free (or being emptied this edge); FETCH captures buf_out.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rd_en_c     = 1'b0;
        case (state_q)
            RD_IDLE: begin
                rd_en_c = !rst && !buf_empty && (!out_valid_q || out_ready);
                if (rd_en_c) begin
                    state_d = RD_FETCH;
                end
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            RD_FETCH: begin
                // A rd_en was only issued with the slot free or draining,
                // so the capture may overwrite the old word.
                out_data_d  = buf_out;
                out_valid_d = 1'b1;
                state_d     = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign gnt       = gnt_c;
    assign wr_en     = wr_en_q;
    assign buf_in    = buf_in_q;
    assign rd_en     = rd_en_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
